// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// load-size encodings, STATUS layout and serializer states.
package mmio_uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam logic [2:0] CTRL_BYTE   = 3'b000;
    localparam logic [2:0] CTRL_HALF   = 3'b001;
    localparam logic [2:0] CTRL_WORD   = 3'b010;
    localparam logic [2:0] CTRL_BYTE_U = 3'b100;
    localparam logic [2:0] CTRL_HALF_U = 3'b101;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    // Narrows a 32-bit register value to the load size requested on DMCtrl.
    function automatic logic [31:0] size_load(input logic [31:0] r, input logic [2:0] ctrl);
        case (ctrl)
            CTRL_BYTE:   size_load = {{24{r[7]}}, r[7:0]};
            CTRL_HALF:   size_load = {{16{r[15]}}, r[15:0]};
            CTRL_BYTE_U: size_load = {24'd0, r[7:0]};
            CTRL_HALF_U: size_load = {16'd0, r[15:0]};
            default:     size_load = r;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; COUNT alone decides which entries are valid,
    // so clearing the array would only cost a reset tree on every bit.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter on the data-memory bus: address decode, same-cycle register
// reads, transmit FIFO and an 8N1 serializer with per-frame baud latching.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd,
    output logic        mmio_hit,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    reg_sel;
    logic          wr_en, push;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    logic          overrun_q, overrun_d;
    logic [15:0]   bauddiv_q, bauddiv_d;
    logic [31:0]   status_word, reg_val;

    tx_state_e     state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic [15:0]   div_q, div_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          period_end;

    logic          unused_bits;
    assign unused_bits = ^{address[1:0], DataWr[31:16]};

    assign mmio_hit = (address[31:4] == BASE_ADDR[31:4]);
    assign reg_sel  = address[3:2];
    assign wr_en    = DMWr && mmio_hit;
    assign push     = wr_en && (reg_sel == REG_TXDATA);

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (fifo_pop),
        .din  (DataWr[7:0]),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_comb begin
        overrun_d = overrun_q;
        if (wr_en && (reg_sel == REG_STATUS) && DataWr[ST_OVERRUN]) overrun_d = 1'b0;
        if (push && fifo_full && !fifo_pop) overrun_d = 1'b1;

        bauddiv_d = bauddiv_q;
        if (wr_en && (reg_sel == REG_BAUDDIV) && (DMCtrl == CTRL_WORD))
            bauddiv_d = (DataWr[15:0] == 16'd0) ? 16'd1 : DataWr[15:0];
    end

    always_comb begin
        status_word = '0;
        status_word[ST_BUSY]    = (state_q != S_IDLE);
        status_word[ST_FULL]    = fifo_full;
        status_word[ST_EMPTY]   = fifo_empty;
        status_word[ST_OVERRUN] = overrun_q;
        status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);

        case (reg_sel)
            REG_STATUS:  reg_val = status_word;
            REG_BAUDDIV: reg_val = {16'd0, bauddiv_q};
            default:     reg_val = '0;
        endcase
    end

    assign DataRd = mmio_hit ? size_load(reg_val, DMCtrl) : 32'd0;

    assign period_end = (baud_cnt_q == div_q - 16'd1);

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        div_d      = div_q;
        data_d     = data_q;
        fifo_pop   = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = baud_cnt_q;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    data_d     = fifo_dout;
                    div_d      = bauddiv_q;
                    baud_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (period_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (period_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (period_end) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next frame so queued bytes leave gap-free.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        data_d   = fifo_dout;
                        div_d    = bauddiv_q;
                        state_d  = S_START;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = data_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            div_q      <= 16'(CLKS_PER_BIT);
            data_q     <= '0;
            tx_q       <= 1'b1;
            overrun_q  <= 1'b0;
            bauddiv_q  <= 16'(CLKS_PER_BIT);
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            overrun_q  <= overrun_d;
            bauddiv_q  <= bauddiv_d;
        end
    end

    assign tx = tx_q;

endmodule
